ibex_mem_arbiter: RTL and testbench

IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

---
 rtl/ibex_mem_arbiter_if.sv | 46 ++++
 rtl/ibex_mem_arbiter.sv | 81 ++++++++
 tb/tb_ibex_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_mem_arbiter_if.sv
// ibex_mem_arbiter_if: instruction, data and shared-bus req/gnt/rvalid signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/bus.
interface ibex_mem_arbiter_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: round-robin arbiter merging instruction and data ports onto one bus,
// with a route FIFO steering in-order responses back to their source.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ibex_mem_arbiter_if.slave   mem,
    output logic                busy_o
);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic                      lock_q, lock_d, sel_q, sel_d, rr_q, rr_d;
    logic                      full, sel, push, pop, head;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full = cnt_q == CW'(MaxOutstanding);
        // a stalled request keeps its slot until granted; otherwise the side not granted last wins
        sel = lock_q ? sel_q : (mem.instr_req_i & mem.data_req_i) ? ~rr_q : mem.data_req_i;
        mem.bus_req_o   = ~full & (sel ? mem.data_req_i : mem.instr_req_i);
        mem.bus_we_o    = sel & mem.data_we_i;
        mem.bus_be_o    = sel ? mem.data_be_i : 4'b1111;
        mem.bus_addr_o  = sel ? mem.data_addr_i : mem.instr_addr_i;
        mem.bus_wdata_o = sel ? mem.data_wdata_i : '0;
        push = mem.bus_req_o & mem.bus_gnt_i;
        mem.instr_gnt_o = push & ~sel;
        mem.data_gnt_o  = push & sel;
        pop  = mem.bus_rvalid_i & (cnt_q != '0);
        head = fifo_q[rptr_q];
        mem.instr_rvalid_o = pop & ~head;
        mem.instr_err_o    = pop & ~head & mem.bus_err_i;
        mem.data_rvalid_o  = pop & head;
        mem.data_err_o     = pop & head & mem.bus_err_i;
        mem.instr_rdata_o  = mem.bus_rdata_i;
        mem.data_rdata_o   = mem.bus_rdata_i;
        busy_o = (cnt_q != '0) | lock_q;
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wptr_q] = sel;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        wptr_d = push ? wrap_inc(wptr_q) : wptr_q;
        rptr_d = pop ? wrap_inc(rptr_q) : rptr_q;
        rr_d   = push ? sel : rr_q;
        lock_d = mem.bus_req_o & ~mem.bus_gnt_i;
        sel_d  = lock_d ? sel : sel_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fifo_q <= '0;
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
            rr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fifo_q <= fifo_d;
            lock_q <= lock_d;
            sel_q  <= sel_d;
            rr_q   <= rr_d;
        end
    end

    spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem.bus_rvalid_i && cnt_q == '0))
        else $warning("bus_rvalid_i with nothing outstanding was dropped");
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the arbiter.
module tb_ibex_mem_arbiter;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    ibex_mem_arbiter_if bus_if ();
    ibex_mem_arbiter #(.MaxOutstanding(MO)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .mem   (bus_if.slave),
        .busy_o(busy)
    );

    int route[$];
    int last_src = 0;
    int locked = -1;
    bit exp_ig, exp_dg;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check();
        bit full, req_sel, e_req, gnt, pop;
        int sel, head;
        #2;
        if (!rst_ni) begin
            route.delete();
            locked = -1;
            last_src = 0;
        end
        full = route.size() == MO;
        if (locked >= 0) sel = locked;
        else if (bus_if.instr_req_i && bus_if.data_req_i) sel = (last_src == 0) ? 1 : 0;
        else sel = bus_if.data_req_i ? 1 : 0;
        req_sel = (sel == 1) ? bus_if.data_req_i : bus_if.instr_req_i;
        e_req = !full && req_sel;
        gnt = e_req && bus_if.bus_gnt_i;
        pop = bus_if.bus_rvalid_i && route.size() > 0;
        head = pop ? route[0] : 0;
        exp_ig = gnt && sel == 0;
        exp_dg = gnt && sel == 1;
        chk("bus_req", bus_if.bus_req_o, e_req);
        chk("instr_gnt", bus_if.instr_gnt_o, exp_ig);
        chk("data_gnt", bus_if.data_gnt_o, exp_dg);
        if (e_req) begin
            chk("bus_we", bus_if.bus_we_o, sel == 1 ? bus_if.data_we_i : 1'b0);
            chk("bus_be", bus_if.bus_be_o, sel == 1 ? bus_if.data_be_i : 4'b1111);
            chk("bus_addr", bus_if.bus_addr_o, sel == 1 ? bus_if.data_addr_i : bus_if.instr_addr_i);
            chk("bus_wdata", bus_if.bus_wdata_o, sel == 1 ? bus_if.data_wdata_i : 32'h0);
        end
        chk("instr_rvalid", bus_if.instr_rvalid_o, pop && head == 0);
        chk("instr_err", bus_if.instr_err_o, pop && head == 0 && bus_if.bus_err_i);
        chk("data_rvalid", bus_if.data_rvalid_o, pop && head == 1);
        chk("data_err", bus_if.data_err_o, pop && head == 1 && bus_if.bus_err_i);
        chk("instr_rdata", bus_if.instr_rdata_o, bus_if.bus_rdata_i);
        chk("data_rdata", bus_if.data_rdata_o, bus_if.bus_rdata_i);
        chk("busy", busy, route.size() > 0 || locked >= 0);
        if (rst_ni) begin
            if (pop) void'(route.pop_front());
            if (gnt) begin
                route.push_back(sel);
                last_src = sel;
                locked = -1;
            end else if (e_req) locked = sel;
        end
    endtask

    task automatic set_bus(input bit ir, input bit dr, input bit g, input bit rv, input bit er);
        bus_if.instr_req_i  = ir;
        bus_if.data_req_i   = dr;
        bus_if.bus_gnt_i    = g;
        bus_if.bus_rvalid_i = rv;
        bus_if.bus_err_i    = er;
    endtask

    task automatic do_reset();
        set_bus(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        settle_check();
        chk("reset_busy", busy, 1'b0);
        adv();
        rst_ni = 1'b1;
    endtask

    initial begin
        bus_if.instr_addr_i = '0;
        bus_if.data_we_i    = 1'b0;
        bus_if.data_be_i    = '0;
        bus_if.data_addr_i  = '0;
        bus_if.data_wdata_i = '0;
        bus_if.bus_rdata_i  = '0;
        set_bus(0, 0, 0, 0, 0);
        #1;
        do_reset();

        // single instruction fetch with response two cycles later
        bus_if.instr_addr_i = 32'h100;
        set_bus(1, 0, 1, 0, 0);
        settle_check();
        chk("t40_gnt", bus_if.instr_gnt_o, 1'b1);
        chk("t40_addr", bus_if.bus_addr_o, 32'h100);
        adv();
        set_bus(0, 0, 0, 0, 0);
        settle_check();
        chk("t40_busy", busy, 1'b1);
        adv();
        bus_if.bus_rdata_i = 32'hDEADBEEF;
        set_bus(0, 0, 0, 1, 0);
        settle_check();
        chk("t40_rvalid", bus_if.instr_rvalid_o, 1'b1);
        chk("t40_rdata", bus_if.instr_rdata_o, 32'hDEADBEEF);
        chk("t40_data_rvalid", bus_if.data_rvalid_o, 1'b0);
        adv();

        // continuous contention alternates starting with data
        do_reset();
        bus_if.data_be_i = 4'b0101;
        bus_if.data_addr_i = 32'h400;
        bus_if.instr_addr_i = 32'h500;
        for (int k = 0; k < 4; k++) begin
            set_bus(1, 1, 1, k > 0, 0);
            settle_check();
            chk("t41_data_gnt", bus_if.data_gnt_o, k % 2 == 0);
            chk("t41_instr_gnt", bus_if.instr_gnt_o, k % 2 == 1);
            chk("t41_be", bus_if.bus_be_o, k % 2 == 0 ? 4'b0101 : 4'b1111);
            adv();
        end

        // stalled instr keeps the bus; data waits then goes next
        bus_if.instr_addr_i = 32'h200;
        bus_if.data_addr_i = 32'h300;
        set_bus(1, 0, 0, 1, 0);
        settle_check();
        chk("t42_addr0", bus_if.bus_addr_o, 32'h200);
        adv();
        for (int k = 0; k < 2; k++) begin
            set_bus(1, 1, 0, 0, 0);
            settle_check();
            chk("t42_addr_held", bus_if.bus_addr_o, 32'h200);
            adv();
        end
        set_bus(1, 1, 1, 0, 0);
        settle_check();
        chk("t42_instr_gnt", bus_if.instr_gnt_o, 1'b1);
        adv();
        set_bus(0, 1, 1, 0, 0);
        settle_check();
        chk("t42_data_gnt", bus_if.data_gnt_o, 1'b1);
        chk("t42_data_addr", bus_if.bus_addr_o, 32'h300);
        adv();

        // in-order responses with per-side error routing
        set_bus(0, 0, 0, 1, 0);
        settle_check();
        chk("t44_instr_rvalid", bus_if.instr_rvalid_o, 1'b1);
        chk("t44_instr_err", bus_if.instr_err_o, 1'b0);
        adv();
        set_bus(0, 0, 0, 1, 1);
        settle_check();
        chk("t44_data_rvalid", bus_if.data_rvalid_o, 1'b1);
        chk("t44_data_err", bus_if.data_err_o, 1'b1);
        adv();

        // outstanding limit blocks the bus even with rvalid in the same cycle
        for (int k = 0; k < 2; k++) begin
            set_bus(1, 1, 1, 0, 0);
            settle_check();
            adv();
        end
        set_bus(1, 1, 1, 1, 0);
        settle_check();
        chk("t43_full_req", bus_if.bus_req_o, 1'b0);
        chk("t43_full_gnt", bus_if.instr_gnt_o | bus_if.data_gnt_o, 1'b0);
        adv();
        set_bus(1, 1, 1, 0, 0);
        settle_check();
        chk("t43_req_again", bus_if.bus_req_o, 1'b1);
        adv();

        // reset with 2 outstanding, then a stray response
        set_bus(0, 0, 0, 0, 0);
        settle_check();
        chk("t45_busy_before", busy, 1'b1);
        rst_ni = 1'b0;
        settle_check();
        chk("t45_busy_rst", busy, 1'b0);
        adv();
        rst_ni = 1'b1;
        set_bus(0, 0, 0, 1, 0);
        settle_check();
        chk("t45_instr_rvalid", bus_if.instr_rvalid_o, 1'b0);
        chk("t45_data_rvalid", bus_if.data_rvalid_o, 1'b0);
        chk("t45_busy", busy, 1'b0);
        adv();

        // randomized traffic honouring req-held-until-gnt
        set_bus(0, 0, 0, 0, 0);
        exp_ig = 0;
        exp_dg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus_if.instr_req_i || exp_ig) begin
                bus_if.instr_req_i  = $urandom_range(0, 2) != 0;
                bus_if.instr_addr_i = $urandom;
            end
            if (!bus_if.data_req_i || exp_dg) begin
                bus_if.data_req_i   = $urandom_range(0, 2) != 0;
                bus_if.data_we_i    = 1'($urandom);
                bus_if.data_be_i    = 4'($urandom);
                bus_if.data_addr_i  = $urandom;
                bus_if.data_wdata_i = $urandom;
            end
            bus_if.bus_gnt_i    = $urandom_range(0, 3) != 0;
            bus_if.bus_rvalid_i = route.size() > 0 && $urandom_range(0, 1) == 1;
            bus_if.bus_err_i    = 1'($urandom);
            bus_if.bus_rdata_i  = $urandom;
            rst_ni = (c % 700) != 350;
            settle_check();
            adv();
        end
        rst_ni = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
